// File: rtl/spi_packet_parser.sv
// SPI packet parser: takes the decoded 6-bit header, collects the MSB-first payload and issues
// register-file write strobes and read requests. Optional PARITY_CHECK_EN adds an even-parity bit.
module spi_packet_parser #(
    parameter int DATA_WL = 16,
    parameter int CNT_WL  = 5
) (
    input  logic               iCLK,
    input  logic               iRSTn,
    input  logic               iCLR,
    input  logic               iEN,
    input  logic               MOSI,
    input  logic [5:0]         iHEADER,
    input  logic               iHEADER_EN,
    output logic               oWR_EN,
    output logic [3:0]         oWR_ADDR,
    output logic [DATA_WL-1:0] oWR_DATA,
    output logic               oRD_REQ,
    output logic               oBUSY,
    output logic               oERR
);

    typedef enum logic {IDLE, PAYLOAD} state_t;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

`ifdef PARITY_CHECK_EN
    localparam int LAST_BIT = DATA_WL;
`else
    localparam int LAST_BIT = DATA_WL - 1;
`endif
    localparam logic [CNT_WL-1:0] CNT_LAST = CNT_WL'(LAST_BIT);

    state_t               state_q, state_d;
    logic [CNT_WL-1:0]    cnt_q, cnt_d;
    logic [DATA_WL-1:0]   shift_q, shift_d;
    logic [DATA_WL-1:0]   data_q, data_d;
    logic [3:0]           addr_q, addr_d;
    logic                 wr_en_q, wr_en_d;
    logic                 rd_req_q, rd_req_d;
    logic                 err_q, err_d;

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            wr_en_q  <= 1'b0;
            rd_req_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            wr_en_q  <= wr_en_d;
            rd_req_q <= rd_req_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        addr_d   = addr_q;
        wr_en_d  = 1'b0;
        rd_req_d = 1'b0;
        err_d    = err_q;

        if (iCLR) begin
            state_d = IDLE;
            cnt_d   = '0;
            shift_d = '0;
            data_d  = '0;
            addr_d  = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // The iEN paired with iHEADER_EN carries a header bit, never payload.
                    if (iHEADER_EN) begin
                        addr_d = iHEADER[3:0];
                        case (iHEADER[5:4])
                            OP_WRITE: begin
                                state_d = PAYLOAD;
                                cnt_d   = '0;
                                shift_d = '0;
                            end
                            OP_READ: rd_req_d = 1'b1;
                            OP_RSVD: err_d    = 1'b1;
                            default: ;
                        endcase
                    end
                end
                PAYLOAD: begin
                    // iHEADER_EN here is the upstream counter wrapping; it is ignored.
                    if (iEN) begin
`ifdef PARITY_CHECK_EN
                        if (cnt_q == CNT_LAST) begin
                            state_d = IDLE;
                            if ((^shift_q ^ MOSI) == 1'b0) begin
                                wr_en_d = 1'b1;
                                data_d  = shift_q;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else begin
                            shift_d = {shift_q[DATA_WL-2:0], MOSI};
                            cnt_d   = cnt_q + 1'b1;
                        end
`else
                        shift_d = {shift_q[DATA_WL-2:0], MOSI};
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_d = IDLE;
                            wr_en_d = 1'b1;
                            data_d  = shift_d;
                        end
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign oWR_EN   = wr_en_q;
    assign oWR_ADDR = addr_q;
    assign oWR_DATA = data_q;
    assign oRD_REQ  = rd_req_q;
    assign oBUSY    = (state_q == PAYLOAD);
    assign oERR     = err_q;

endmodule

// File: tb/tb_spi_packet_parser.sv
// Directed bench for spi_packet_parser; expected writes/reads go into a queue that a
// negedge monitor pops whenever the DUT strobes oWR_EN or oRD_REQ.
module tb_spi_packet_parser;

    localparam int DATA_WL = 16;
    localparam int CNT_WL  = 5;

    logic               iCLK, iRSTn, iCLR, iEN, MOSI, iHEADER_EN;
    logic [5:0]         iHEADER;
    logic               oWR_EN, oRD_REQ, oBUSY, oERR;
    logic [3:0]         oWR_ADDR;
    logic [DATA_WL-1:0] oWR_DATA;

    typedef struct packed {
        logic               is_rd;
        logic [3:0]         addr;
        logic [DATA_WL-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int compared   = 0;
    int mismatched = 0;

    spi_packet_parser #(.DATA_WL(DATA_WL), .CNT_WL(CNT_WL)) dut (
        .iCLK(iCLK), .iRSTn(iRSTn), .iCLR(iCLR), .iEN(iEN), .MOSI(MOSI),
        .iHEADER(iHEADER), .iHEADER_EN(iHEADER_EN),
        .oWR_EN(oWR_EN), .oWR_ADDR(oWR_ADDR), .oWR_DATA(oWR_DATA),
        .oRD_REQ(oRD_REQ), .oBUSY(oBUSY), .oERR(oERR)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic send_header(input logic [5:0] h);
        iHEADER = h; iHEADER_EN = 1'b1; iEN = 1'b1; MOSI = h[0];
        tick();
        iHEADER_EN = 1'b0; iEN = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        MOSI = b; iEN = 1'b1;
        tick();
        iEN = 1'b0;
    endtask

    // spur_at: payload bit index that also carries a stray reserved-opcode header pulse
    task automatic send_word(input logic [DATA_WL-1:0] w, input int spur_at);
        check("busy_start", 32'(oBUSY), 32'd1);
        for (int i = DATA_WL - 1; i >= 0; i--) begin
            if ((DATA_WL - 1 - i) == spur_at) begin
                iHEADER = 6'b11_0111; iHEADER_EN = 1'b1;
            end
            send_bit(w[i]);
            iHEADER_EN = 1'b0;
        end
`ifdef PARITY_CHECK_EN
        send_bit(^w);
`endif
        check("busy_end", 32'(oBUSY), 32'd0);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [DATA_WL-1:0] d, input int spur_at);
        exp_q.push_back('{1'b0, a, d});
        send_header({2'b01, a});
        send_word(d, spur_at);
    endtask

    task automatic pulse_clr();
        iCLR = 1'b1;
        tick();
        iCLR = 1'b0;
    endtask

    always @(negedge iCLK) begin
        if (iRSTn && (oWR_EN || oRD_REQ)) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_strobe: wr_en=%0b rd_req=%0b addr=%0h data=%0h, expected none",
                         oWR_EN, oRD_REQ, oWR_ADDR, oWR_DATA);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                compared++;
                if (oRD_REQ !== e.is_rd || oWR_EN !== !e.is_rd || oWR_ADDR !== e.addr ||
                    (!e.is_rd && oWR_DATA !== e.data)) begin
                    mismatched++;
                    $display("FAIL strobe: got rd=%0b wr=%0b addr=%0h data=%0h, expected rd=%0b addr=%0h data=%0h",
                             oRD_REQ, oWR_EN, oWR_ADDR, oWR_DATA, e.is_rd, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        iRSTn = 1'b0; iCLR = 1'b0; iEN = 1'b0; MOSI = 1'b0;
        iHEADER = '0; iHEADER_EN = 1'b0;
        #12;
        check("rst_wr_en",  32'(oWR_EN),   32'd0);
        check("rst_addr",   32'(oWR_ADDR), 32'd0);
        check("rst_data",   32'(oWR_DATA), 32'd0);
        check("rst_rd_req", 32'(oRD_REQ),  32'd0);
        check("rst_busy",   32'(oBUSY),    32'd0);
        check("rst_err",    32'(oERR),     32'd0);
        iRSTn = 1'b1;
        tick();

        // Write, then a back-to-back write whose header lands in the oWR_EN cycle
        do_write(4'd3, 16'hA5C3, -1);
        do_write(4'd1, 16'h8001, -1);
        tick(); tick(); tick();
        check("data_hold", 32'(oWR_DATA), 32'h8001);
        check("addr_hold", 32'(oWR_ADDR), 32'd1);

        // Bit strobes in IDLE without a header do nothing
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("idle_ign_busy", 32'(oBUSY), 32'd0);

        // Read: one-cycle request, latency 1
        exp_q.push_back('{1'b1, 4'hF, '0});
        send_header(6'b10_1111);
        check("rd_req_hi",  32'(oRD_REQ),  32'd1);
        check("rd_busy",    32'(oBUSY),    32'd0);
        check("rd_addr",    32'(oWR_ADDR), 32'hF);
        tick();
        check("rd_req_lo",  32'(oRD_REQ),  32'd0);

        // NOP latches address only
        send_header(6'b00_0100);
        tick();
        check("nop_addr", 32'(oWR_ADDR), 32'd4);
        check("nop_busy", 32'(oBUSY),    32'd0);

        // Stray header pulse mid-payload must not disturb the packet
        do_write(4'd2, 16'h5A3C, 2);
        check("spur_err",  32'(oERR),     32'd0);
        check("spur_addr", 32'(oWR_ADDR), 32'd2);

        // Abort mid-payload, then a clean write
        send_header(6'b01_1001);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        pulse_clr();
        check("abort_busy", 32'(oBUSY),    32'd0);
        check("abort_addr", 32'(oWR_ADDR), 32'd0);
        do_write(4'd5, 16'h1234, -1);

        // Reserved opcode: sticky error until clear
        send_header(6'b11_0000);
        check("rsvd_err", 32'(oERR), 32'd1);
        tick(); tick(); tick(); tick();
        check("rsvd_err_held", 32'(oERR), 32'd1);
        pulse_clr();
        check("clr_err", 32'(oERR), 32'd0);

        // Asynchronous reset mid-payload
        send_header(6'b01_0111);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("pre_rst_busy", 32'(oBUSY), 32'd1);
        #2;
        iRSTn = 1'b0;
        #1;
        check("arst_busy",  32'(oBUSY),    32'd0);
        check("arst_addr",  32'(oWR_ADDR), 32'd0);
        check("arst_data",  32'(oWR_DATA), 32'd0);
        check("arst_wr_en", 32'(oWR_EN),   32'd0);
        check("arst_err",   32'(oERR),     32'd0);
        #3;
        iRSTn = 1'b1;
        tick();

`ifdef PARITY_CHECK_EN
        // Good parity writes; bad parity sets the error and suppresses the write
        exp_q.push_back('{1'b0, 4'd6, 16'h0001});
        send_header(6'b01_0110);
        for (int i = DATA_WL - 1; i >= 0; i--) send_bit(i == 0);
        send_bit(1'b1);
        check("par_ok_err", 32'(oERR), 32'd0);
        send_header(6'b01_0110);
        for (int i = DATA_WL - 1; i >= 0; i--) send_bit(i == 0);
        send_bit(1'b0);
        check("par_bad_err",  32'(oERR),  32'd1);
        check("par_bad_busy", 32'(oBUSY), 32'd0);
`endif

        tick(); tick(); tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
